// File: rtl/versatile_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | versatile_fifo_pkg : shared widths, thresholds and helpers for FIFOs  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package versatile_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_AF_MARGIN  = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/versatile_fifo_sync_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | versatile_fifo_sync_ctrl_if : push/pop and status bundle of the FIFO  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface versatile_fifo_sync_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   fill_level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, empty, full, almost_full, fill_level, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, empty, full, almost_full, fill_level, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/versatile_fifo_dptam_dw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | versatile_fifo_dptam_dw : true dual-port RAM, registered reads        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module versatile_fifo_dptam_dw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] adr_a,
  input  logic [DATA_WIDTH-1:0] d_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] adr_b,
  input  logic [DATA_WIDTH-1:0] d_b,
  output logic [DATA_WIDTH-1:0] q_b
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Reads return the old contents on a same-address write; callers bypass.
  always_ff @(posedge clk) begin
    q_a <= mem[adr_a];
    q_b <= mem[adr_b];
    if (we_a) mem[adr_a] <= d_a;
    if (we_b) mem[adr_b] <= d_b;
  end
endmodule
`default_nettype wire

// File: rtl/versatile_fifo_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | versatile_fifo_sync_ctrl : single-clock FWFT FIFO around the DP RAM   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module versatile_fifo_sync_ctrl
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - DEF_AF_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst,
  versatile_fifo_sync_ctrl_if.slave bus
);
  localparam int                  CW         = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH    = CW'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_AF_LEVEL = CW'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic                  empty, full, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [DATA_WIDTH-1:0] q_b;
  logic [DATA_WIDTH-1:0] q_a_unused;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == C_DEPTH);
    wr_ok       = bus.wr_en && !full && !bus.clear;
    rd_ok       = bus.rd_en && !empty && !bus.clear;
    rd_ptr_next = rd_ptr_q + ADDR_WIDTH'(rd_ok);

    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_ok);
    rd_ptr_d    = rd_ptr_next;
    count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
    overflow_d  = overflow_q  || (bus.wr_en && full);
    underflow_d = underflow_q || (bus.rd_en && empty);
    // The RAM can't show a word written to the address it is reading this
    // cycle, so capture it for the head output instead.
    byp_sel_d   = wr_ok && (wr_ptr_q == rd_ptr_next);
    byp_data_d  = wr_ok ? bus.wr_data : byp_data_q;

    if (bus.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      byp_sel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      byp_sel_q   <= byp_sel_d;
      byp_data_q  <= byp_data_d;
    end
  end

  versatile_fifo_dptam_dw #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we_a  (wr_ok),
    .adr_a (wr_ptr_q),
    .d_a   (bus.wr_data),
    .q_a   (q_a_unused),
    .we_b  (1'b0),
    .adr_b (rd_ptr_next),
    .d_b   ({DATA_WIDTH{1'b0}}),
    .q_b   (q_b)
  );

  assign bus.rd_data     = byp_sel_q ? byp_data_q : q_b;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= C_AF_LEVEL);
  assign bus.fill_level  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_versatile_fifo_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_versatile_fifo_sync_ctrl : directed bench with a queue model       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_versatile_fifo_sync_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  versatile_fifo_sync_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  versatile_fifo_sync_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .AF_LEVEL   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: a queue of up to four words plus two sticky bits.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  bit         m_was_full;
  bit         m_was_empty;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.clear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_was_full  = (mq.size() == 4);
      m_was_empty = (mq.size() == 0);
      if (bus.wr_en && m_was_full)  m_ovf = 1'b1;
      if (bus.rd_en && m_was_empty) m_udf = 1'b1;
      if (bus.rd_en && !m_was_empty) void'(mq.pop_front());
      if (bus.wr_en && !m_was_full)  mq.push_back(bus.wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_empty", {31'b0, bus.empty}, {31'b0, mq.size() == 0});
    chk("m_full", {31'b0, bus.full}, {31'b0, mq.size() == 4});
    chk("m_afull", {31'b0, bus.almost_full}, {31'b0, mq.size() >= 3});
    chk("m_fill", {29'b0, bus.fill_level}, mq.size());
    chk("m_ovf", {31'b0, bus.overflow}, {31'b0, m_ovf});
    chk("m_udf", {31'b0, bus.underflow}, {31'b0, m_udf});
    if (mq.size() != 0) chk("m_rd_data", {24'b0, bus.rd_data}, {24'b0, mq[0]});
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.clear   = c;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_empty", {31'b0, bus.empty}, 32'd1);
    chk("reset_fill", {29'b0, bus.fill_level}, 32'd0);
    chk("reset_ovf", {31'b0, bus.overflow}, 32'd0);

    // Write into empty: visible right after the edge via the bypass.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("wr_empty_flag", {31'b0, bus.empty}, 32'd0);
    chk("wr_empty_data", {24'b0, bus.rd_data}, 32'hA5);
    chk("wr_empty_fill", {29'b0, bus.fill_level}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_to_empty", {31'b0, bus.empty}, 32'd1);

    // Fill to D, overflow, then a dropped write alongside a read at full.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 3) begin
        chk("af_at_3", {31'b0, bus.almost_full}, 32'd1);
        chk("notfull_at_3", {31'b0, bus.full}, 32'd0);
      end
    end
    chk("full_at_4", {31'b0, bus.full}, 32'd1);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("ovf_set", {31'b0, bus.overflow}, 32'd1);
    chk("fill_after_drop", {29'b0, bus.fill_level}, 32'd4);
    chk("head_01", {24'b0, bus.rd_data}, 32'h01);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_rw_fill", {29'b0, bus.fill_level}, 32'd3);
    chk("head_02", {24'b0, bus.rd_data}, 32'h02);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("head_03", {24'b0, bus.rd_data}, 32'h03);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("head_04", {24'b0, bus.rd_data}, 32'h04);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_empty", {31'b0, bus.empty}, 32'd1);

    // Steady state at fill 1: one read and one write every cycle.
    step(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      chk("fill1_data", {24'b0, bus.rd_data}, 32'h10 + i);
      chk("fill1_level", {29'b0, bus.fill_level}, 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around at fill 2.
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      chk("wrap_data", {24'b0, bus.rd_data}, 32'h20 + i - 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", {24'b0, bus.rd_data}, 32'h29);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, then clear with fill 2 and competing requests.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", {31'b0, bus.underflow}, 32'd1);
    chk("udf_fill", {29'b0, bus.fill_level}, 32'd0);
    step(1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    chk("clear_empty", {31'b0, bus.empty}, 32'd1);
    chk("clear_udf", {31'b0, bus.underflow}, 32'd0);
    chk("clear_ovf", {31'b0, bus.overflow}, 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_clear_data", {24'b0, bus.rd_data}, 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges at fill 3.
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_empty", {31'b0, bus.empty}, 32'd1);
    chk("async_rst_fill", {29'b0, bus.fill_level}, 32'd0);
    chk("async_rst_af", {31'b0, bus.almost_full}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_data", {24'b0, bus.rd_data}, 32'h77);
    chk("post_rst_fill", {29'b0, bus.fill_level}, 32'd1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
